scalar_dispatch: RTL and testbench
==================================

// Module: scalar_dispatch
// PURPOSE
//  Scoreboard dispatch stage for the scalar pipeline. Accepts one decoded scalar
//  instruction per cycle from decode and checks structural (FU busy) and WAW hazards.
//  On a clean check, writes the instruction into the scalar FU status table (FUST)
//  and the register result status (RST) table. Exports the FUST to the downstream
//  issue stage, and clears entries on FU writeback.
// PARAMETERS
//  NUM_FU   3   scalar FUs; index 0=ALU, 1=LD_ST, 2=BRANCH
//  NUM_REG  32  architectural scalar registers
//  TAG_W    2   FU tag width; tag 2'b11 = READY (no pending producer)
// PORTS
//  CLK          in   1            clock, rising edge
//  nRST         in   1            asynchronous active-low reset
//  d_valid      in   1            decode holds a valid instruction
//  d_ready      out  1            dispatch accepts this cycle (comb.)
//  d_fu         in   TAG_W        target FU index (0..NUM_FU-1)
//  d_rd         in   5            destination register
//  d_rs1        in   5            source register 1
//  d_rs2        in   5            source register 2
//  d_wen        in   1            instruction writes rd
//  wb_valid     in   1            an FU completes this cycle
//  wb_fu        in   TAG_W        completing FU index
//  fust_busy    out  NUM_FU       row busy flags
//  fust_r       out  NUM_FU*5     row destination registers
//  fust_r1      out  NUM_FU*5     row source 1 registers
//  fust_r2      out  NUM_FU*5     row source 2 registers
//  fust_t1      out  NUM_FU*TAG_W producer tag for r1 (READY if none)
//  fust_t2      out  NUM_FU*TAG_W producer tag for r2 (READY if none)
//  stall_struct out  1            d_valid and target row busy
//  stall_waw    out  1            d_valid, d_wen, rd!=0 and rd pending in RST
// BEHAVIOUR
//  - Reset: all fust_busy=0; r/r1/r2=0; t1/t2=READY; every RST entry idle.
//    d_ready, stall_* follow comb. from reset state.
//  - d_ready = !stall_struct & !stall_waw. Transfer = d_valid & d_ready.
//  - Hazard checks use registered state only. A writeback in the same cycle does
//    not unblock dispatch until the next cycle.
//  - On transfer, at the next edge:
//    - Row[d_fu] gets busy=1, r=d_rd, r1=d_rs1, r2=d_rs2.
//    - t1 = RST[rs1].tag if RST[rs1] is pending, else READY. t2 is set the same way.
//    - If d_wen and rd!=0: RST[rd] = {pending, d_fu}.
//    - Table outputs reflect the new row 1 cycle after transfer.
//  - x0: never marked pending; rs==0 always gives READY. d_wen with rd=0 is not a WAW hazard.
//  - On wb_valid, at the next edge:
//    - Row[wb_fu].busy=0.
//    - Every RST entry whose tag==wb_fu is cleared.
//    - Every t1/t2 field ==wb_fu in any row becomes READY (wakeup).
//  - Simultaneous transfer + writeback:
//    - If the new instruction's source tag == wb_fu, the stored tag is READY, so no
//      wakeup is lost.
//    - If the new rd's producer is also the writeback FU, the RST ends {pending, d_fu}:
//      the dispatch write wins over the clear.
//    - wb_fu == d_fu in the same cycle cannot occur, because the row is busy, so it stalls.
//  - wb_valid for a non-busy row: no state change. d_fu >= NUM_FU: treated as busy,
//    so the instruction stalls forever. This is a decode bug, flagged by an assertion.
//  - Reset asserted mid-operation clears all rows and the RST immediately. In-flight
//    FU results are discarded by their own resets.
// TESTING
//  - Reset: nRST=0 then 1 -> fust_busy=3'b000, all t=2'b11, d_ready=1 with d_valid=0.
//  - ALU add x5<-x1,x2 accepted -> next cycle busy[0]=1, r=5, t1=t2=11, RST[5]={1,0}.
//  - Then LD_ST x6<-x5,x0 -> row1 t1=00, t2=11. Then ALU x7 -> stall_struct=1,
//    d_ready=0 until wb_fu=0.
//  - WAW: BRANCH with d_wen, rd=5 while x5 pending -> stall_waw=1. wb_valid, wb_fu=0
//    -> stall_waw=0 next cycle, row1 t1 -> 11.
//  - Same cycle as wb_fu=0, dispatch LD_ST reading x5 -> stored t1=11, not 00.
//  - Dispatch with rd=0, d_wen=1 -> RST untouched; a later instruction writing x0
//    has no stall_waw.

Source files
------------

// File: rtl/scalar_dispatch_if.sv
// Decode-to-dispatch handshake, writeback strobe and exported FU status table.
// The master side is decode/writeback; the slave side is the dispatch stage.
interface scalar_dispatch_if #(
  parameter int NUM_FU = 3,
  parameter int TAG_W  = 2
);
  logic                    d_valid;
  logic                    d_ready;
  logic [TAG_W-1:0]        d_fu;
  logic [4:0]              d_rd;
  logic [4:0]              d_rs1;
  logic [4:0]              d_rs2;
  logic                    d_wen;
  logic                    wb_valid;
  logic [TAG_W-1:0]        wb_fu;
  logic [NUM_FU-1:0]       fust_busy;
  logic [NUM_FU*5-1:0]     fust_r;
  logic [NUM_FU*5-1:0]     fust_r1;
  logic [NUM_FU*5-1:0]     fust_r2;
  logic [NUM_FU*TAG_W-1:0] fust_t1;
  logic [NUM_FU*TAG_W-1:0] fust_t2;
  logic                    stall_struct;
  logic                    stall_waw;

  modport master (
    output d_valid, d_fu, d_rd, d_rs1, d_rs2, d_wen, wb_valid, wb_fu,
    input  d_ready, fust_busy, fust_r, fust_r1, fust_r2, fust_t1, fust_t2,
           stall_struct, stall_waw
  );

  modport slave (
    input  d_valid, d_fu, d_rd, d_rs1, d_rs2, d_wen, wb_valid, wb_fu,
    output d_ready, fust_busy, fust_r, fust_r1, fust_r2, fust_t1, fust_t2,
           stall_struct, stall_waw
  );
endinterface

// File: rtl/scalar_dispatch.sv
// Scoreboard dispatch: structural/WAW hazard check, FU status table and
// register result status table with writeback wakeup.
module scalar_dispatch #(
  parameter int NUM_FU  = 3,
  parameter int NUM_REG = 32,
  parameter int TAG_W   = 2
) (
  input logic               CLK,
  input logic               nRST,
  scalar_dispatch_if.slave  bus
);
  localparam logic [TAG_W-1:0] READY = '1;

  logic [NUM_FU-1:0]            busy_q, busy_d;
  logic [NUM_FU-1:0][4:0]       r_q, r_d;
  logic [NUM_FU-1:0][4:0]       r1_q, r1_d;
  logic [NUM_FU-1:0][4:0]       r2_q, r2_d;
  logic [NUM_FU-1:0][TAG_W-1:0] t1_q, t1_d;
  logic [NUM_FU-1:0][TAG_W-1:0] t2_q, t2_d;
  logic [NUM_REG-1:0]           pend_q, pend_d;
  logic [NUM_REG-1:0][TAG_W-1:0] tag_q, tag_d;

  logic             row_busy;
  logic             wb_hit;
  logic             xfer;
  logic [TAG_W-1:0] src1_tag;
  logic [TAG_W-1:0] src2_tag;

  // Out-of-range FU indices fall through as busy, so they stall forever.
  always_comb begin
    row_busy = 1'b1;
    wb_hit   = 1'b0;
    for (int i = 0; i < NUM_FU; i++) begin
      if (bus.d_fu == TAG_W'(i))  row_busy = busy_q[i];
      if (bus.wb_fu == TAG_W'(i)) wb_hit   = bus.wb_valid & busy_q[i];
    end
  end

  assign bus.stall_struct = bus.d_valid & row_busy;
  assign bus.stall_waw    = bus.d_valid & bus.d_wen & (bus.d_rd != 5'd0) & pend_q[bus.d_rd];
  assign bus.d_ready      = ~bus.stall_struct & ~bus.stall_waw;
  assign xfer             = bus.d_valid & bus.d_ready;

  // A producer completing this very cycle must not be captured as a pending tag.
  always_comb begin
    src1_tag = READY;
    src2_tag = READY;
    if (bus.d_rs1 != 5'd0 && pend_q[bus.d_rs1] &&
        !(wb_hit && tag_q[bus.d_rs1] == bus.wb_fu))
      src1_tag = tag_q[bus.d_rs1];
    if (bus.d_rs2 != 5'd0 && pend_q[bus.d_rs2] &&
        !(wb_hit && tag_q[bus.d_rs2] == bus.wb_fu))
      src2_tag = tag_q[bus.d_rs2];
  end

  always_comb begin
    busy_d = busy_q;
    r_d    = r_q;
    r1_d   = r1_q;
    r2_d   = r2_q;
    t1_d   = t1_q;
    t2_d   = t2_q;
    pend_d = pend_q;
    tag_d  = tag_q;

    if (wb_hit) begin
      for (int i = 0; i < NUM_FU; i++) begin
        if (bus.wb_fu == TAG_W'(i)) busy_d[i] = 1'b0;
        if (t1_q[i] == bus.wb_fu)   t1_d[i]   = READY;
        if (t2_q[i] == bus.wb_fu)   t2_d[i]   = READY;
      end
      for (int j = 0; j < NUM_REG; j++) begin
        if (pend_q[j] && tag_q[j] == bus.wb_fu) begin
          pend_d[j] = 1'b0;
          tag_d[j]  = READY;
        end
      end
    end

    // Applied after the writeback clear so a new producer wins over it.
    if (xfer) begin
      for (int i = 0; i < NUM_FU; i++) begin
        if (bus.d_fu == TAG_W'(i)) begin
          busy_d[i] = 1'b1;
          r_d[i]    = bus.d_rd;
          r1_d[i]   = bus.d_rs1;
          r2_d[i]   = bus.d_rs2;
          t1_d[i]   = src1_tag;
          t2_d[i]   = src2_tag;
        end
      end
      if (bus.d_wen && bus.d_rd != 5'd0) begin
        pend_d[bus.d_rd] = 1'b1;
        tag_d[bus.d_rd]  = bus.d_fu;
      end
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      busy_q <= '0;
      r_q    <= '0;
      r1_q   <= '0;
      r2_q   <= '0;
      t1_q   <= '1;
      t2_q   <= '1;
      pend_q <= '0;
      tag_q  <= '1;
    end else begin
      busy_q <= busy_d;
      r_q    <= r_d;
      r1_q   <= r1_d;
      r2_q   <= r2_d;
      t1_q   <= t1_d;
      t2_q   <= t2_d;
      pend_q <= pend_d;
      tag_q  <= tag_d;
    end
  end

  assign bus.fust_busy = busy_q;
  assign bus.fust_r    = r_q;
  assign bus.fust_r1   = r1_q;
  assign bus.fust_r2   = r2_q;
  assign bus.fust_t1   = t1_q;
  assign bus.fust_t2   = t2_q;

  a_fu_in_range: assert property (@(posedge CLK) disable iff (!nRST)
    bus.d_valid |-> (bus.d_fu < TAG_W'(NUM_FU)));
endmodule

// File: tb/tb_scalar_dispatch.sv
// Directed vector bench for scalar_dispatch: one table of per-cycle vectors
// plus short hand-written sequences for wakeup timing and mid-run reset.
module tb_scalar_dispatch;
  logic CLK;
  logic nRST;
  int   n_cmp;
  int   n_bad;

  scalar_dispatch_if #(.NUM_FU(3), .TAG_W(2)) bus ();

  scalar_dispatch #(.NUM_FU(3), .NUM_REG(32), .TAG_W(2)) dut (
    .CLK  (CLK),
    .nRST (nRST),
    .bus  (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic        d_valid;
    logic [1:0]  d_fu;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        wen;
    logic        wb_valid;
    logic [1:0]  wb_fu;
    logic        e_ready;
    logic        e_ss;
    logic        e_sw;
    logic [2:0]  e_busy;
    logic [14:0] e_r;
    logic [5:0]  e_t1;
    logic [5:0]  e_t2;
  } vec_t;

  vec_t vecs[19];

  function automatic vec_t mk(input logic dv, input logic [1:0] fu, input logic [4:0] rd,
                              input logic [4:0] rs1, input logic [4:0] rs2, input logic wen,
                              input logic wbv, input logic [1:0] wbf,
                              input logic er, input logic ess, input logic esw,
                              input logic [2:0] eb, input logic [14:0] erv,
                              input logic [5:0] et1, input logic [5:0] et2);
    vec_t v;
    v.d_valid = dv;  v.d_fu = fu;  v.rd = rd;  v.rs1 = rs1;  v.rs2 = rs2;  v.wen = wen;
    v.wb_valid = wbv;  v.wb_fu = wbf;
    v.e_ready = er;  v.e_ss = ess;  v.e_sw = esw;  v.e_busy = eb;
    v.e_r = erv;  v.e_t1 = et1;  v.e_t2 = et2;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic dv, input logic [1:0] fu, input logic [4:0] rd,
                       input logic [4:0] rs1, input logic [4:0] rs2, input logic wen,
                       input logic wbv, input logic [1:0] wbf);
    bus.d_valid  = dv;
    bus.d_fu     = fu;
    bus.d_rd     = rd;
    bus.d_rs1    = rs1;
    bus.d_rs2    = rs2;
    bus.d_wen    = wen;
    bus.wb_valid = wbv;
    bus.wb_fu    = wbf;
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;

    // Columns: dv fu rd rs1 rs2 wen | wbv wbf || ready ss sw busy fust_r t1 t2
    vecs[0]  = mk(0, 0,  0, 0, 0, 0, 0, 0, 1, 0, 0, 3'b000, 15'd0,    6'h3f, 6'h3f);
    vecs[1]  = mk(1, 0,  5, 1, 2, 1, 0, 0, 1, 0, 0, 3'b000, 15'd0,    6'h3f, 6'h3f);
    vecs[2]  = mk(1, 1,  6, 5, 0, 1, 0, 0, 1, 0, 0, 3'b001, 15'd5,    6'h3f, 6'h3f);
    vecs[3]  = mk(1, 0,  7, 3, 4, 1, 0, 0, 0, 1, 0, 3'b011, 15'd197,  6'h33, 6'h3f);
    vecs[4]  = mk(1, 2,  5, 0, 0, 1, 0, 0, 0, 0, 1, 3'b011, 15'd197,  6'h33, 6'h3f);
    vecs[5]  = mk(1, 2,  5, 0, 0, 1, 1, 0, 0, 0, 1, 3'b011, 15'd197,  6'h33, 6'h3f);
    vecs[6]  = mk(1, 2,  5, 0, 0, 1, 0, 0, 1, 0, 0, 3'b010, 15'd197,  6'h3f, 6'h3f);
    vecs[7]  = mk(0, 0,  0, 0, 0, 0, 1, 1, 1, 0, 0, 3'b110, 15'd5317, 6'h3f, 6'h3f);
    vecs[8]  = mk(0, 0,  0, 0, 0, 0, 1, 2, 1, 0, 0, 3'b100, 15'd5317, 6'h3f, 6'h3f);
    vecs[9]  = mk(1, 0,  5, 1, 1, 1, 0, 0, 1, 0, 0, 3'b000, 15'd5317, 6'h3f, 6'h3f);
    vecs[10] = mk(1, 1,  9, 5, 5, 1, 1, 0, 1, 0, 0, 3'b001, 15'd5317, 6'h3f, 6'h3f);
    vecs[11] = mk(1, 2,  0, 0, 5, 1, 0, 0, 1, 0, 0, 3'b010, 15'd5413, 6'h3f, 6'h3f);
    vecs[12] = mk(1, 0,  0, 9, 0, 1, 0, 0, 1, 0, 0, 3'b110, 15'd293,  6'h3f, 6'h3f);
    vecs[13] = mk(0, 0,  0, 0, 0, 0, 0, 0, 1, 0, 0, 3'b111, 15'd288,  6'h3d, 6'h3f);
    vecs[14] = mk(1, 0,  3, 0, 0, 1, 0, 0, 0, 1, 0, 3'b111, 15'd288,  6'h3d, 6'h3f);
    vecs[15] = mk(0, 0,  0, 0, 0, 0, 1, 1, 1, 0, 0, 3'b111, 15'd288,  6'h3d, 6'h3f);
    vecs[16] = mk(0, 0,  0, 0, 0, 0, 0, 0, 1, 0, 0, 3'b101, 15'd288,  6'h3f, 6'h3f);
    vecs[17] = mk(0, 0,  0, 0, 0, 0, 1, 1, 1, 0, 0, 3'b101, 15'd288,  6'h3f, 6'h3f);
    vecs[18] = mk(0, 0,  0, 0, 0, 0, 0, 0, 1, 0, 0, 3'b101, 15'd288,  6'h3f, 6'h3f);

    drive(0, 0, 0, 0, 0, 0, 0, 0);
    nRST = 1'b0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    nRST = 1'b1;

    for (int k = 0; k < 19; k++) begin
      @(posedge CLK);
      #1;
      drive(vecs[k].d_valid, vecs[k].d_fu, vecs[k].rd, vecs[k].rs1, vecs[k].rs2,
            vecs[k].wen, vecs[k].wb_valid, vecs[k].wb_fu);
      #3;
      check($sformatf("v%0d d_ready", k),      32'(bus.d_ready),      32'(vecs[k].e_ready));
      check($sformatf("v%0d stall_struct", k), 32'(bus.stall_struct), 32'(vecs[k].e_ss));
      check($sformatf("v%0d stall_waw", k),    32'(bus.stall_waw),    32'(vecs[k].e_sw));
      check($sformatf("v%0d fust_busy", k),    32'(bus.fust_busy),    32'(vecs[k].e_busy));
      check($sformatf("v%0d fust_r", k),       32'(bus.fust_r),       32'(vecs[k].e_r));
      check($sformatf("v%0d fust_t1", k),      32'(bus.fust_t1),      32'(vecs[k].e_t1));
      check($sformatf("v%0d fust_t2", k),      32'(bus.fust_t2),      32'(vecs[k].e_t2));
    end

    // Row 0 busy: ALU dispatch stalls in the writeback cycle, accepted the cycle after.
    @(posedge CLK);
    #1;
    drive(1, 0, 10, 0, 0, 1, 1, 0);
    #3;
    check("seq wb-cycle d_ready", 32'(bus.d_ready), 32'd0);
    check("seq wb-cycle stall_struct", 32'(bus.stall_struct), 32'd1);
    @(posedge CLK);
    #1;
    drive(1, 0, 10, 0, 0, 1, 0, 0);
    #3;
    check("seq post-wb d_ready", 32'(bus.d_ready), 32'd1);
    check("seq post-wb busy", 32'(bus.fust_busy), 32'(3'b100));
    @(posedge CLK);
    #1;
    drive(1, 1, 10, 0, 0, 1, 0, 0);
    #3;
    check("seq new row0 busy", 32'(bus.fust_busy), 32'(3'b101));
    check("seq new row0 r", 32'(bus.fust_r), 32'd298);
    check("seq waw on x10", 32'(bus.stall_waw), 32'd1);

    // Asynchronous reset mid-operation clears the table and the RST at once.
    #1;
    nRST = 1'b0;
    #1;
    check("rst busy", 32'(bus.fust_busy), 32'd0);
    check("rst t1", 32'(bus.fust_t1), 32'h3f);
    check("rst r", 32'(bus.fust_r), 32'd0);
    check("rst waw cleared", 32'(bus.stall_waw), 32'd0);
    check("rst d_ready", 32'(bus.d_ready), 32'd1);
    @(negedge CLK);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    nRST = 1'b1;
    @(posedge CLK);
    #1;
    check("post-rst busy", 32'(bus.fust_busy), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
